alu_share_arbiter: RTL and testbench

Round-robin arbiter that shares one 32-bit ALU instance among NUM_REQ requesters. Each requester submits opcode, operands and shift amount over a valid/ready handshake. The block registers the winning operation onto the ALU and captures result and carry. It returns them to the owning requester over a per-requester valid/ready response channel, with an error flag for opcodes the ALU does not define.

---
 rtl/alu_share_arbiter.sv | 207 ++++++++++++++++++++
 tb/tb_alu_share_arbiter.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_share_arbiter.sv
// alu_share_arbiter
// Round-robin front end that time-shares one external combinational ALU
// among NUM_REQ requesters. A request is latched onto the registered ALU
// inputs and given one full cycle to settle. The result and carry are then
// captured and returned to the owner, which holds the response until the
// owner takes it.
module alu_share_arbiter #(
   parameter int                 NUM_REQ    = 4,
   parameter int                 WIDTH      = 32,
   parameter int                 OP_W       = 4,
   parameter int                 SH_W       = 5,
   parameter logic [2**OP_W-1:0] LEGAL_MASK = 16'h03B2,
   parameter int                 IDW        = $clog2(NUM_REQ)
) (
   input  logic                    clk,
   input  logic                    rst,
   // request channel
   input  logic [NUM_REQ-1:0]      req_valid,
   output logic [NUM_REQ-1:0]      req_ready,
   input  logic [NUM_REQ*OP_W-1:0] req_opcode,
   input  logic [NUM_REQ*WIDTH-1:0] req_a,
   input  logic [NUM_REQ*WIDTH-1:0] req_b,
   input  logic [NUM_REQ*SH_W-1:0] req_shift,
   // response channel
   output logic [NUM_REQ-1:0]      rsp_valid,
   input  logic [NUM_REQ-1:0]      rsp_ready,
   output logic [WIDTH-1:0]        rsp_result,
   output logic                    rsp_carry,
   output logic                    rsp_err,
   // shared ALU
   output logic [OP_W-1:0]         alu_opcode,
   output logic [WIDTH-1:0]        alu_input1,
   output logic [WIDTH-1:0]        alu_input2,
   output logic [SH_W-1:0]         alu_shift,
   input  logic [WIDTH-1:0]        alu_result,
   input  logic                    alu_carry,
   // status
   output logic                    busy,
   output logic [IDW-1:0]          grant_id
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      RESP  = 2'd2
   } state_t;

   state_t               state_q, state_d;
   logic [IDW-1:0]       ptr_q, ptr_d;
   logic [IDW-1:0]       grant_q, grant_d;
   logic                 legal_q, legal_d;
   logic [NUM_REQ-1:0]   rsp_valid_q, rsp_valid_d;
   logic [WIDTH-1:0]     result_q, result_d;
   logic                 carry_q, carry_d;
   logic                 err_q, err_d;
   logic [OP_W-1:0]      alu_op_q, alu_op_d;
   logic [WIDTH-1:0]     alu_a_q, alu_a_d;
   logic [WIDTH-1:0]     alu_b_q, alu_b_d;
   logic [SH_W-1:0]      alu_sh_q, alu_sh_d;

   // unpacked per-requester views of the packed request buses
   logic [OP_W-1:0]      opc_arr [NUM_REQ];
   logic [WIDTH-1:0]     a_arr   [NUM_REQ];
   logic [WIDTH-1:0]     b_arr   [NUM_REQ];
   logic [SH_W-1:0]      sh_arr  [NUM_REQ];

   logic [IDW-1:0]       winner;
   logic                 win_found;
   logic [NUM_REQ-1:0]   winner_onehot;
   logic [NUM_REQ-1:0]   grant_onehot;
   logic [IDW-1:0]       grant_inc;

   genvar gi;
   generate
      for (gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
         assign opc_arr[gi] = req_opcode[gi*OP_W  +: OP_W];
         assign a_arr[gi]   = req_a     [gi*WIDTH +: WIDTH];
         assign b_arr[gi]   = req_b     [gi*WIDTH +: WIDTH];
         assign sh_arr[gi]  = req_shift [gi*SH_W  +: SH_W];
      end
   endgenerate

   // rotating priority search: first valid requester at ptr, ptr+1, ... (mod NUM_REQ)
   always_comb begin
      logic [IDW:0] idx;
      winner    = '0;
      win_found = 1'b0;
      idx       = '0;
      for (int k = 0; k < NUM_REQ; k++) begin
         idx = {1'b0, ptr_q} + (IDW+1)'(k);
         if (idx >= (IDW+1)'(NUM_REQ)) begin
            idx = idx - (IDW+1)'(NUM_REQ);
         end
         if (!win_found && req_valid[idx[IDW-1:0]]) begin
            win_found = 1'b1;
            winner    = idx[IDW-1:0];
         end
      end
   end

   // owner index plus one, wrapping for non-power-of-two requester counts
   always_comb begin
      logic [IDW:0] nxt;
      nxt = {1'b0, grant_q} + (IDW+1)'(1);
      if (nxt >= (IDW+1)'(NUM_REQ)) begin
         nxt = '0;
      end
      grant_inc = nxt[IDW-1:0];
   end

   assign winner_onehot = NUM_REQ'(1) << winner;
   assign grant_onehot  = NUM_REQ'(1) << grant_q;

   // ready only to the current winner, only while idle and out of reset
   assign req_ready = (state_q == IDLE && !rst && win_found) ? winner_onehot : '0;

   // next-state and datapath updates
   always_comb begin
      state_d     = state_q;
      ptr_d       = ptr_q;
      grant_d     = grant_q;
      legal_d     = legal_q;
      rsp_valid_d = rsp_valid_q;
      result_d    = result_q;
      carry_d     = carry_q;
      err_d       = err_q;
      alu_op_d    = alu_op_q;
      alu_a_d     = alu_a_q;
      alu_b_d     = alu_b_q;
      alu_sh_d    = alu_sh_q;
      case (state_q)
         IDLE: begin
            // ALU inputs only change on an accept, so they stay quiet while idle
            if (win_found) begin
               alu_op_d = opc_arr[winner];
               alu_a_d  = a_arr[winner];
               alu_b_d  = b_arr[winner];
               alu_sh_d = sh_arr[winner];
               grant_d  = winner;
               legal_d  = LEGAL_MASK[opc_arr[winner]];
               state_d  = ISSUE;
            end
         end
         ISSUE: begin
            // undefined opcodes still take this cycle so latency is fixed
            result_d    = legal_q ? alu_result : '0;
            carry_d     = legal_q ? alu_carry  : 1'b0;
            err_d       = !legal_q;
            rsp_valid_d = grant_onehot;
            state_d     = RESP;
         end
         RESP: begin
            if (rsp_ready[grant_q]) begin
               rsp_valid_d = '0;
               ptr_d       = grant_inc;
               state_d     = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // state and output registers; reset drops any operation in flight
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= IDLE;
         ptr_q       <= '0;
         grant_q     <= '0;
         legal_q     <= 1'b0;
         rsp_valid_q <= '0;
         result_q    <= '0;
         carry_q     <= 1'b0;
         err_q       <= 1'b0;
         alu_op_q    <= '0;
         alu_a_q     <= '0;
         alu_b_q     <= '0;
         alu_sh_q    <= '0;
      end else begin
         state_q     <= state_d;
         ptr_q       <= ptr_d;
         grant_q     <= grant_d;
         legal_q     <= legal_d;
         rsp_valid_q <= rsp_valid_d;
         result_q    <= result_d;
         carry_q     <= carry_d;
         err_q       <= err_d;
         alu_op_q    <= alu_op_d;
         alu_a_q     <= alu_a_d;
         alu_b_q     <= alu_b_d;
         alu_sh_q    <= alu_sh_d;
      end
   end

   assign rsp_valid  = rsp_valid_q;
   assign rsp_result = result_q;
   assign rsp_carry  = carry_q;
   assign rsp_err    = err_q;
   assign alu_opcode = alu_op_q;
   assign alu_input1 = alu_a_q;
   assign alu_input2 = alu_b_q;
   assign alu_shift  = alu_sh_q;
   assign busy       = (state_q != IDLE);
   assign grant_id   = grant_q;

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Directed bench for alu_share_arbiter with a small behavioural ALU attached.
module tb_alu_share_arbiter;

   localparam int N  = 4;
   localparam int W  = 32;
   localparam int OW = 4;
   localparam int SW = 5;

   logic            clk = 1'b0;
   logic            rst;
   logic [N-1:0]    req_valid;
   logic [N-1:0]    req_ready;
   logic [N*OW-1:0] req_opcode;
   logic [N*W-1:0]  req_a;
   logic [N*W-1:0]  req_b;
   logic [N*SW-1:0] req_shift;
   logic [N-1:0]    rsp_valid;
   logic [N-1:0]    rsp_ready;
   logic [W-1:0]    rsp_result;
   logic            rsp_carry;
   logic            rsp_err;
   logic [OW-1:0]   alu_opcode;
   logic [W-1:0]    alu_input1;
   logic [W-1:0]    alu_input2;
   logic [SW-1:0]   alu_shift;
   logic [W-1:0]    alu_result;
   logic            alu_carry;
   logic            busy;
   logic [1:0]      grant_id;

   int tests = 0;
   int fails = 0;

   alu_share_arbiter dut (
      .clk(clk), .rst(rst),
      .req_valid(req_valid), .req_ready(req_ready), .req_opcode(req_opcode),
      .req_a(req_a), .req_b(req_b), .req_shift(req_shift),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_result(rsp_result),
      .rsp_carry(rsp_carry), .rsp_err(rsp_err),
      .alu_opcode(alu_opcode), .alu_input1(alu_input1), .alu_input2(alu_input2),
      .alu_shift(alu_shift), .alu_result(alu_result), .alu_carry(alu_carry),
      .busy(busy), .grant_id(grant_id)
   );

   always #5 clk = ~clk;

   // behavioural ALU: carry mirrors result MSB; undefined opcodes give junk with carry set
   always_comb begin
      logic [2*W-1:0] rot;
      rot        = {alu_input1, alu_input1} >> alu_shift;
      alu_result = 32'hDEADBEEF;
      case (alu_opcode)
         4'd1: alu_result = ($signed(alu_input1) > $signed(alu_input2)) ? alu_input1 : alu_input2;
         4'd4: alu_result = ~(alu_input1 & alu_input2);
         4'd5: alu_result = rot[W-1:0];
         4'd7: alu_result = $unsigned($signed(alu_input1) >>> alu_shift);
         4'd8: alu_result = ($signed(alu_input1) < $signed(alu_input2)) ? alu_input1 : alu_input2;
         4'd9: alu_result = alu_input1 | alu_input2;
         default: alu_result = 32'hDEADBEEF;
      endcase
      alu_carry = (alu_opcode == 4'd1 || alu_opcode == 4'd4 || alu_opcode == 4'd5 ||
                   alu_opcode == 4'd7 || alu_opcode == 4'd8 || alu_opcode == 4'd9)
                  ? alu_result[W-1] : 1'b1;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_req(input int i, input logic [3:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [4:0] sh);
      req_opcode[i*OW +: OW] = op;
      req_a[i*W +: W]        = a;
      req_b[i*W +: W]        = b;
      req_shift[i*SW +: SW]  = sh;
   endtask

   int order [5] = '{0, 1, 3, 0, 3};

   initial begin
      rst = 1'b1; req_valid = '0; rsp_ready = '0;
      req_opcode = '0; req_a = '0; req_b = '0; req_shift = '0;
      req_valid[0] = 1'b1;
      #2;
      chk("rst_req_ready", 32'(req_ready), 32'h0);
      chk("rst_rsp_valid", 32'(rsp_valid), 32'h0);
      chk("rst_busy", 32'(busy), 32'h0);
      chk("rst_alu_op", 32'(alu_opcode), 32'h0);
      chk("rst_grant", 32'(grant_id), 32'h0);
      tick();
      rst = 1'b0;
      req_valid = '0;
      $display("[TB] reset released");

      // single OR from requester 0
      set_req(0, 4'd9, 32'h0F0F0000, 32'h000000FF, 5'd0);
      req_valid = 4'b0001;
      #1;
      chk("or_req_ready", 32'(req_ready), 32'h1);
      tick();
      req_valid = '0;
      chk("or_busy", 32'(busy), 32'h1);
      chk("or_alu_op", 32'(alu_opcode), 32'h9);
      chk("or_alu_a", alu_input1, 32'h0F0F0000);
      chk("or_rsp_valid_early", 32'(rsp_valid), 32'h0);
      tick();
      chk("or_rsp_valid", 32'(rsp_valid), 32'h1);
      chk("or_result", rsp_result, 32'h0F0F00FF);
      chk("or_err", 32'(rsp_err), 32'h0);
      rsp_ready = 4'b0001;
      tick();
      rsp_ready = '0;
      chk("or_done_valid", 32'(rsp_valid), 32'h0);
      chk("or_done_busy", 32'(busy), 32'h0);
      $display("[TB] OR req0 result=%h", 32'h0F0F00FF);

      // round-robin order after a fresh reset
      rst = 1'b1;
      #1;
      chk("rr_rst_valid", 32'(rsp_valid), 32'h0);
      tick();
      rst = 1'b0;
      for (int i = 0; i < N; i++) set_req(i, 4'd9, 32'h10000000 + 32'(i), 32'h0, 5'd0);
      req_valid = 4'b1011;
      rsp_ready = 4'b1111;
      for (int s = 0; s < 5; s++) begin
         if (s == 3) req_valid = 4'b1001;
         #1;
         chk("rr_req_ready", 32'(req_ready), 32'(1) << order[s]);
         tick();
         chk("rr_grant_id", 32'(grant_id), 32'(order[s]));
         tick();
         chk("rr_rsp_valid", 32'(rsp_valid), 32'(1) << order[s]);
         chk("rr_result", rsp_result, 32'h10000000 + 32'(order[s]));
         tick();
         $display("[TB] RR step %0d grant=%0d", s, order[s]);
      end
      req_valid = '0;
      rsp_ready = '0;

      // SRA with stalled response; ptr is 0 here
      set_req(2, 4'd7, 32'h80000000, 32'h0, 5'd4);
      req_valid = 4'b0100;
      #1;
      chk("sra_req_ready", 32'(req_ready), 32'h4);
      tick();
      set_req(0, 4'd9, 32'h1, 32'h0, 5'd0);
      req_valid = 4'b0001;
      rsp_ready = 4'b1011;
      tick();
      for (int c = 0; c < 5; c++) begin
         chk("sra_hold_valid", 32'(rsp_valid), 32'h4);
         chk("sra_hold_result", rsp_result, 32'hF8000000);
         chk("sra_hold_carry", 32'(rsp_carry), 32'h1);
         chk("sra_hold_ready", 32'(req_ready), 32'h0);
         chk("sra_hold_busy", 32'(busy), 32'h1);
         tick();
      end
      req_valid = '0;
      rsp_ready = 4'b0100;
      tick();
      rsp_ready = '0;
      chk("sra_done_valid", 32'(rsp_valid), 32'h0);
      $display("[TB] SRA req2 result=%h", 32'hF8000000);

      // unsupported opcode 0 from requester 1 (ptr is 3)
      set_req(1, 4'd0, 32'h1, 32'h2, 5'd0);
      req_valid = 4'b0010;
      #1;
      chk("bad_req_ready", 32'(req_ready), 32'h2);
      tick();
      req_valid = '0;
      tick();
      chk("bad_rsp_valid", 32'(rsp_valid), 32'h2);
      chk("bad_err", 32'(rsp_err), 32'h1);
      chk("bad_result", rsp_result, 32'h0);
      chk("bad_carry", 32'(rsp_carry), 32'h0);
      rsp_ready = 4'b0010;
      tick();
      rsp_ready = '0;
      $display("[TB] opcode0 req1 err=1");

      // reset during ISSUE (ptr is 2)
      set_req(1, 4'd9, 32'hFFFF0000, 32'h0, 5'd0);
      req_valid = 4'b0010;
      tick();
      chk("rstiss_busy_before", 32'(busy), 32'h1);
      set_req(3, 4'd1, 32'h5, 32'hFFFFFFFF, 5'd0);
      req_valid = 4'b1000;
      rst = 1'b1;
      #1;
      chk("rstiss_busy", 32'(busy), 32'h0);
      chk("rstiss_alu_op", 32'(alu_opcode), 32'h0);
      chk("rstiss_alu_a", alu_input1, 32'h0);
      chk("rstiss_grant", 32'(grant_id), 32'h0);
      chk("rstiss_req_ready", 32'(req_ready), 32'h0);
      chk("rstiss_result", rsp_result, 32'h0);
      tick();
      rst = 1'b0;
      #1;
      chk("rstiss_no_rsp", 32'(rsp_valid), 32'h0);
      chk("rstiss_req3_ready", 32'(req_ready), 32'h8);
      tick();
      req_valid = '0;
      chk("rstiss_no_rsp2", 32'(rsp_valid), 32'h0);
      tick();
      chk("max_rsp_valid", 32'(rsp_valid), 32'h8);
      chk("max_result", rsp_result, 32'h5);
      rsp_ready = 4'b1000;
      tick();
      rsp_ready = '0;
      $display("[TB] reset-in-issue then MAX req3 result=%h", 32'h5);

      // back-to-back ROR then MIN from requester 0 (ptr is 0)
      set_req(0, 4'd5, 32'h00000001, 32'h0, 5'd1);
      req_valid = 4'b0001;
      rsp_ready = 4'b0001;
      #1;
      chk("ror_req_ready", 32'(req_ready), 32'h1);
      tick();
      tick();
      chk("ror_result", rsp_result, 32'h80000000);
      chk("ror_carry", 32'(rsp_carry), 32'h1);
      set_req(0, 4'd8, 32'h5, 32'h3, 5'd0);
      #1;
      chk("min_no_early_ready", 32'(req_ready), 32'h0);
      tick();
      chk("ror_done_valid", 32'(rsp_valid), 32'h0);
      chk("min_req_ready", 32'(req_ready), 32'h1);
      tick();
      req_valid = '0;
      chk("min_alu_op", 32'(alu_opcode), 32'h8);
      tick();
      chk("min_rsp_valid", 32'(rsp_valid), 32'h1);
      chk("min_result", rsp_result, 32'h3);
      chk("min_carry", 32'(rsp_carry), 32'h0);
      tick();
      rsp_ready = '0;
      chk("min_done_valid", 32'(rsp_valid), 32'h0);
      chk("idle_alu_hold", alu_input1, 32'h5);
      $display("[TB] ROR=%h then MIN=%h", 32'h80000000, 32'h3);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
